// File: rtl/hm0360_pkg.sv
// Shared types and defaults for the HM0360 DVP capture path.
package hm0360_pkg;

  localparam int unsigned HM0360_DEFAULT_H = 320;
  localparam int unsigned HM0360_DEFAULT_V = 240;

  typedef enum logic [1:0] {
    StIdle,
    StWaitInit,
    StWaitVs,
    StFrame
  } cap_state_e;

  typedef struct packed {
    logic       sof;
    logic       eol;
    logic [7:0] data;
  } px_entry_t;

  localparam int unsigned PX_ENTRY_W = $bits(px_entry_t);

endpackage

// File: rtl/px_fifo.sv
// Synchronous FIFO; extra pointer MSB separates full from empty.
module px_fifo #(
  parameter int unsigned WIDTH = 10,
  parameter int unsigned DEPTH = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = (AW + 1)'(1);

  logic [AW:0]      wr_ptr_q, rd_ptr_q;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             do_rd, do_wr;

  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign do_rd   = rd_en && !empty;
  // A pop in the same cycle frees the slot, so a push into a full FIFO is fine then.
  assign do_wr   = wr_en && (!full || do_rd);
  assign rd_data = mem_q[rd_ptr_q[AW-1:0]];

  // Pointer update.
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (do_wr) wr_ptr_q <= wr_ptr_q + PTR_ONE;
      if (do_rd) rd_ptr_q <= rd_ptr_q + PTR_ONE;
    end
  end

  // Storage write; contents need no reset.
  always_ff @(posedge clock) begin
    if (do_wr) mem_q[wr_ptr_q[AW-1:0]] <= wr_data;
  end

endmodule

// File: rtl/hm0360_dvp_capture.sv
// HM0360 DVP capture: oversamples the sensor bus, frames pixels, buffers them in a FIFO.
module hm0360_dvp_capture
  import hm0360_pkg::*;
#(
  parameter int unsigned H_ACTIVE    = HM0360_DEFAULT_H,
  parameter int unsigned V_ACTIVE    = HM0360_DEFAULT_V,
  parameter int unsigned FIFO_DEPTH  = 16,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       init_active,
  input  logic       capture_en,
  input  logic       cam_pclk,
  input  logic       cam_vsync,
  input  logic       cam_hsync,
  input  logic [7:0] cam_data,
  output logic [7:0] px_data,
  output logic       px_valid,
  input  logic       px_ready,
  output logic       px_sof,
  output logic       px_eol,
  output logic       frame_done,
  output logic       overflow,
  output logic       line_err
);

  localparam int unsigned COL_W = $clog2(H_ACTIVE + 1);
  localparam int unsigned ROW_W = $clog2(V_ACTIVE + 2);
  localparam logic [COL_W-1:0] COL_FULL = COL_W'(H_ACTIVE);
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(H_ACTIVE - 1);
  localparam logic [COL_W-1:0] COL_ONE  = COL_W'(1);
  localparam logic [ROW_W-1:0] ROW_FULL = ROW_W'(V_ACTIVE);
  localparam logic [ROW_W-1:0] ROW_MAX  = ROW_W'(V_ACTIVE + 1);
  localparam logic [ROW_W-1:0] ROW_ONE  = ROW_W'(1);

  // Synchronizers: all camera lines share the same depth so they stay aligned to pclk.
  logic [SYNC_STAGES-1:0]      pclk_sync, vsync_sync, hsync_sync;
  logic [SYNC_STAGES-1:0][7:0] data_sync;
  logic [SYNC_STAGES:0]        warm_q;
  logic                        pclk_q, vsync_q, hsync_q, init_q;
  logic                        pclk_s, vsync_s, hsync_s, edges_ok;
  logic [7:0]                  data_s;
  logic                        pclk_rise, vs_rise, vs_fall, hs_fall, init_rise;

  // FSM and datapath state.
  cap_state_e       state_q, state_d;
  logic [COL_W-1:0] col_q, col_d;
  logic [ROW_W-1:0] row_q, row_d;
  logic             push_q, push_d;
  px_entry_t        entry_q, entry_d;
  logic             frame_done_q, frame_done_d;
  logic             overflow_q, line_err_q, line_err_set;

  // FIFO interface.
  logic [PX_ENTRY_W-1:0] fifo_rdata;
  px_entry_t             head;
  logic                  fifo_full, fifo_empty, pop, drop;

  // Synchronizer chains plus registered copies for edge detection.
  always_ff @(posedge clock) begin
    if (reset) begin
      pclk_sync  <= '0;
      vsync_sync <= '0;
      hsync_sync <= '0;
      data_sync  <= '0;
      warm_q     <= '0;
      pclk_q     <= 1'b0;
      vsync_q    <= 1'b0;
      hsync_q    <= 1'b0;
      init_q     <= 1'b0;
    end else begin
      pclk_sync  <= {pclk_sync[SYNC_STAGES-2:0], cam_pclk};
      vsync_sync <= {vsync_sync[SYNC_STAGES-2:0], cam_vsync};
      hsync_sync <= {hsync_sync[SYNC_STAGES-2:0], cam_hsync};
      data_sync  <= {data_sync[SYNC_STAGES-2:0], cam_data};
      warm_q     <= {warm_q[SYNC_STAGES-1:0], 1'b1};
      pclk_q     <= pclk_s;
      vsync_q    <= vsync_s;
      hsync_q    <= hsync_s;
      init_q     <= init_active;
    end
  end

  assign pclk_s  = pclk_sync[SYNC_STAGES-1];
  assign vsync_s = vsync_sync[SYNC_STAGES-1];
  assign hsync_s = hsync_sync[SYNC_STAGES-1];
  assign data_s  = data_sync[SYNC_STAGES-1];

  // Edges are ignored until the chains hold real samples; otherwise a vsync that is
  // already high when reset drops would look like a fresh frame start.
  assign edges_ok  = warm_q[SYNC_STAGES];
  assign pclk_rise = edges_ok && pclk_s && !pclk_q;
  assign vs_rise   = edges_ok && vsync_s && !vsync_q;
  assign vs_fall   = edges_ok && !vsync_s && vsync_q;
  assign hs_fall   = edges_ok && !hsync_s && hsync_q;
  assign init_rise = init_active && !init_q;

  // State, counters, push stage and sticky flags.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= StIdle;
      col_q        <= '0;
      row_q        <= '0;
      push_q       <= 1'b0;
      entry_q      <= '0;
      frame_done_q <= 1'b0;
      overflow_q   <= 1'b0;
      line_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      col_q        <= col_d;
      row_q        <= row_d;
      push_q       <= push_d;
      entry_q      <= entry_d;
      frame_done_q <= frame_done_d;
      overflow_q   <= overflow_q | drop;
      line_err_q   <= line_err_q | line_err_set;
    end
  end

  // Next-state: framing of pixels by line and frame.
  always_comb begin
    state_d      = state_q;
    col_d        = col_q;
    row_d        = row_q;
    push_d       = 1'b0;
    entry_d      = entry_q;
    frame_done_d = 1'b0;
    line_err_set = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (capture_en) state_d = StWaitInit;
      end
      StWaitInit: begin
        if (!init_active) state_d = StWaitVs;
      end
      StWaitVs: begin
        if (vs_rise) begin
          state_d = StFrame;
          col_d   = '0;
          row_d   = '0;
        end
      end
      StFrame: begin
        if (pclk_rise && hsync_s) begin
          push_d       = 1'b1;
          entry_d.sof  = (row_q == '0) && (col_q == '0);
          entry_d.eol  = (col_q == COL_LAST);
          entry_d.data = data_s;
          if (col_q != COL_FULL) col_d = col_q + COL_ONE;
        end
        if (hs_fall) begin
          if (col_d != COL_FULL) line_err_set = 1'b1;
          col_d = '0;
          if (row_q != ROW_MAX) row_d = row_q + ROW_ONE;
        end
        if (vs_fall) begin
          if (row_d != ROW_FULL) line_err_set = 1'b1;
          frame_done_d = 1'b1;
          row_d        = '0;
          col_d        = '0;
          state_d      = capture_en ? StWaitVs : StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    // Initializer restarting takes priority over everything; buffered pixels survive.
    if (init_rise) begin
      state_d      = StWaitInit;
      col_d        = '0;
      row_d        = '0;
      push_d       = 1'b0;
      frame_done_d = 1'b0;
      line_err_set = 1'b0;
    end
  end

  assign pop  = !fifo_empty && px_ready;
  assign drop = push_q && fifo_full && !pop;

  px_fifo #(
    .WIDTH(PX_ENTRY_W),
    .DEPTH(FIFO_DEPTH)
  ) u_px_fifo (
    .clock  (clock),
    .reset  (reset),
    .wr_en  (push_q),
    .wr_data(entry_q),
    .rd_en  (pop),
    .rd_data(fifo_rdata),
    .full   (fifo_full),
    .empty  (fifo_empty)
  );

  assign head       = fifo_rdata;
  // Head fields are forced to zero while empty so no stale entry leaks out.
  assign px_valid   = !fifo_empty;
  assign px_data    = px_valid ? head.data : 8'h00;
  assign px_sof     = px_valid && head.sof;
  assign px_eol     = px_valid && head.eol;
  assign frame_done = frame_done_q;
  assign overflow   = overflow_q;
  assign line_err   = line_err_q;

endmodule

// File: tb/tb_hm0360_dvp_capture.sv
// Scoreboard bench for hm0360_dvp_capture with a small sensor model.
module tb_hm0360_dvp_capture;

  localparam int unsigned H = 4;
  localparam int unsigned V = 2;
  localparam int unsigned DEPTH = 4;

  logic       clock = 1'b0;
  logic       reset, init_active, capture_en;
  logic       cam_pclk, cam_vsync, cam_hsync;
  logic [7:0] cam_data;
  logic [7:0] px_data;
  logic       px_valid, px_ready, px_sof, px_eol;
  logic       frame_done, overflow, line_err;

  always #5 clock = ~clock;

  hm0360_dvp_capture #(
    .H_ACTIVE   (H),
    .V_ACTIVE   (V),
    .FIFO_DEPTH (DEPTH),
    .SYNC_STAGES(2)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .init_active(init_active),
    .capture_en (capture_en),
    .cam_pclk   (cam_pclk),
    .cam_vsync  (cam_vsync),
    .cam_hsync  (cam_hsync),
    .cam_data   (cam_data),
    .px_data    (px_data),
    .px_valid   (px_valid),
    .px_ready   (px_ready),
    .px_sof     (px_sof),
    .px_eol     (px_eol),
    .frame_done (frame_done),
    .overflow   (overflow),
    .line_err   (line_err)
  );

  typedef struct {
    bit       sof;
    bit       eol;
    bit [7:0] data;
  } exp_px_t;

  exp_px_t    exp_q[$];
  int         checks = 0;
  int         failures = 0;
  int         ready_mode = 1;  // 0: hold off, 1: random, 2: always ready
  int         fd_count = 0;
  int         valid_cycles = 0;
  int         exp_fd = 0;
  bit         exp_overflow = 0;
  bit         exp_line_err = 0;
  bit         armed = 0;       // model: capture is waiting for a vsync rise
  bit         in_frame = 0;    // model: current sensor frame is being captured
  int         ph = 2;
  bit         seq_data = 0;
  logic [7:0] seq_val = 8'h10;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Monitor: drives px_ready, counts pulses and compares every accepted pixel.
  initial begin
    exp_px_t e;
    px_ready = 1'b0;
    forever begin
      @(negedge clock);
      case (ready_mode)
        0:       px_ready = 1'b0;
        1:       px_ready = ($urandom_range(3) != 0);
        default: px_ready = 1'b1;
      endcase
      #1;
      if (frame_done === 1'b1) fd_count++;
      if (px_valid === 1'b1) valid_cycles++;
      if (px_valid === 1'b1 && px_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_pixel: got data %0h sof %0b eol %0b, expected no pixel",
                   px_data, px_sof, px_eol);
        end else begin
          e = exp_q.pop_front();
          check("px_word", 32'({px_sof, px_eol, px_data}), 32'({e.sof, e.eol, e.data}));
        end
      end
    end
  end

  initial begin
    #900_000;
    $display("FAIL watchdog: got no finish, expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    repeat (ph) @(negedge clock);
    cam_pclk = 1'b1;
    repeat (ph) @(negedge clock);
    cam_pclk = 1'b0;
  endtask

  // One sensor frame; row-indexed hooks inject init release, capture drop or reset.
  task automatic send_frame(input int nlines, input int short_row, input int short_len,
                            input int hold_limit, input int init_drop_row,
                            input int reset_row, input int cap_drop_row);
    int      kept;
    int      len;
    bit      lerr;
    exp_px_t e;
    kept = 0;
    ph = $urandom_range(3, 2);
    cam_vsync = 1'b1;
    in_frame = armed;
    armed = 0;
    lerr = (nlines != V);
    repeat ($urandom_range(3, 1)) tick();
    for (int r = 0; r < nlines; r++) begin
      if (r == init_drop_row) begin
        init_active = 1'b0;
        armed = capture_en;
      end
      if (r == cap_drop_row) capture_en = 1'b0;
      if (r == reset_row) begin
        check("valid_before_reset", 32'(px_valid), 32'd1);
        reset = 1'b1;
        @(negedge clock);
        check("valid_after_reset", 32'(px_valid), 32'd0);
        check("overflow_after_reset", 32'(overflow), 32'd0);
        check("line_err_after_reset", 32'(line_err), 32'd0);
        exp_q.delete();
        reset = 1'b0;
        in_frame = 0;
        armed = capture_en && !init_active;
        exp_overflow = 0;
        exp_line_err = 0;
      end
      len = (r == short_row) ? short_len : H;
      if (len != H) lerr = 1;
      cam_hsync = 1'b1;
      for (int c = 0; c < len; c++) begin
        if (seq_data) begin
          cam_data = seq_val;
          seq_val = seq_val + 8'd1;
        end else begin
          cam_data = 8'($urandom);
        end
        if (in_frame) begin
          if (hold_limit == 0 || kept < hold_limit) begin
            e.sof = (r == 0 && c == 0);
            e.eol = (c == H - 1);
            e.data = cam_data;
            exp_q.push_back(e);
          end else begin
            exp_overflow = 1;
          end
          kept++;
        end
        tick();
      end
      cam_hsync = 1'b0;
      repeat ($urandom_range(3, 1)) tick();
    end
    cam_vsync = 1'b0;
    if (in_frame) begin
      exp_fd++;
      if (lerr) exp_line_err = 1;
      armed = capture_en;
    end
    in_frame = 0;
    repeat ($urandom_range(3, 2)) tick();
  endtask

  task automatic normal_frame();
    send_frame(V, -1, 0, 0, -1, -1, -1);
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    ready_mode = 1;
    while (exp_q.size() != 0 && n < 3000) begin
      @(negedge clock);
      n++;
    end
    check({name, "_drain"}, 32'(exp_q.size()), 32'd0);
    repeat (20) @(negedge clock);
  endtask

  task automatic check_flags(input string name);
    check({name, "_frame_done"}, 32'(fd_count), 32'(exp_fd));
    check({name, "_overflow"}, 32'(overflow), 32'(exp_overflow));
    check({name, "_line_err"}, 32'(line_err), 32'(exp_line_err));
    check({name, "_valid_idle"}, 32'(px_valid), 32'd0);
  endtask

  initial begin
    longint t0;
    reset = 1'b1;
    init_active = 1'b0;
    capture_en = 1'b0;
    cam_pclk = 1'b0;
    cam_vsync = 1'b0;
    cam_hsync = 1'b0;
    cam_data = 8'h00;
    repeat (5) @(negedge clock);
    check("reset_valid", 32'(px_valid), 32'd0);
    check("reset_data", 32'(px_data), 32'd0);
    check("reset_frame_done", 32'(frame_done), 32'd0);
    check("reset_overflow", 32'(overflow), 32'd0);
    check("reset_line_err", 32'(line_err), 32'd0);
    reset = 1'b0;

    // Basic frame with sequential data 0x10..0x17.
    capture_en = 1'b1;
    repeat (10) @(negedge clock);
    armed = 1;
    seq_data = 1;
    seq_val = 8'h10;
    normal_frame();
    seq_data = 0;
    drain("basic");
    check_flags("basic");

    // Initializer holding capture off while the sensor streams.
    init_active = 1'b1;
    armed = 0;
    repeat (5) @(negedge clock);
    valid_cycles = 0;
    t0 = $time;
    while ($time - t0 < 10_000) normal_frame();
    check("init_hold_no_valid", 32'(valid_cycles), 32'd0);
    send_frame(V, -1, 0, 0, 1, -1, -1);
    normal_frame();
    drain("init");
    check_flags("init");

    // FIFO overflow with the consumer stalled for a whole frame.
    ready_mode = 0;
    seq_data = 1;
    seq_val = 8'h10;
    send_frame(V, -1, 0, DEPTH, -1, -1, -1);
    seq_data = 0;
    repeat (20) @(negedge clock);
    check("ovf_flag", 32'(overflow), 32'd1);
    check("ovf_valid_held", 32'(px_valid), 32'd1);
    check("ovf_frame_done", 32'(fd_count), 32'(exp_fd));
    drain("ovf");
    check_flags("ovf");

    // Short line sets the sticky error; a clean frame afterwards keeps it.
    send_frame(V, 1, 3, 0, -1, -1, -1);
    repeat (10) @(negedge clock);
    check("short_line_err", 32'(line_err), 32'd1);
    normal_frame();
    drain("lerr");
    check_flags("lerr");

    // Reset in the middle of a frame with pixels buffered.
    ready_mode = 0;
    send_frame(V, -1, 0, 0, -1, 1, -1);
    ready_mode = 1;
    normal_frame();
    drain("rst");
    check_flags("rst");

    // capture_en dropped mid-frame finishes that frame only.
    send_frame(V, -1, 0, 0, -1, -1, 1);
    drain("capdrop");
    check_flags("capdrop");
    valid_cycles = 0;
    normal_frame();
    repeat (20) @(negedge clock);
    check("capdrop_no_valid", 32'(valid_cycles), 32'd0);
    capture_en = 1'b1;
    repeat (10) @(negedge clock);
    armed = 1;
    normal_frame();
    drain("caprise");
    check_flags("caprise");

    // Random frames with occasional line/row errors.
    for (int i = 0; i < 6; i++) begin
      int nl;
      int sr;
      nl = $urandom_range(V + 1, V - 1);
      sr = ($urandom_range(1) != 0) ? int'($urandom_range(nl - 1)) : -1;
      send_frame(nl, sr, $urandom_range(H + 1, 1), 0, -1, -1, -1);
    end
    drain("rand");
    check_flags("rand");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
